row_fetch_ctrl: RTL and testbench
=================================

// Module: row_fetch_ctrl
// PURPOSE
// Sequences sparse-row index fetches from the matrix ROM pair (A/B aux ROM + A/B index ROM) for signature generation.
// Takes a row request (row number + matrix select), reads the aux word (base address, Hamming weight hw), then streams hw indices out.
// Output is a valid/ready stream with last-flag for vec_generator-style consumers.
// Replaces the dat_load/vec_gen address sequencing inside the signing FSM with one pipelined, backpressure-aware controller.
// PARAMETERS
// ROW_W   7   aux ROM address width (row number)
// ADDR_W  15  index ROM address width
// IDX_W   14  index word width
// HW_W    8   Hamming-weight field width
// AUX_W   23  aux word width; layout {base[ADDR_W-1:0], hw[HW_W-1:0]}
// PORTS
// clk        in   1       rising-edge clock
// rst_b      in   1       synchronous reset, active low
// req_valid  in   1       row request valid
// req_ready  out  1       high only in IDLE
// req_row    in   ROW_W   row number (quotient of dividend/50)
// req_mat    in   1       0 = matrix B, 1 = matrix A
// abort      in   1       flush current row, return to IDLE
// mat_sel    out  1       latched req_mat; drives external A/B ROM output muxes
// aux_addr   out  ROW_W   aux ROM address (registered)
// aux_dat    in   AUX_W   aux ROM data, 1-cycle synchronous read latency
// mem_addr   out  ADDR_W  index ROM address (registered)
// mem_en     out  1       index ROM read issue strobe
// mem_dout   in   IDX_W   index ROM data, valid cycle after mem_en
// idx_valid  out  1       index stream valid
// idx_ready  in   1       consumer ready
// idx_data   out  IDX_W   index value
// idx_last   out  1       marks hw-th index of row
// done       out  1       one-cycle pulse: row complete
// BEHAVIOUR
// Reset (rst_b=0 at posedge): state IDLE; req_ready=1; mat_sel, aux_addr, mem_addr, mem_en, idx_valid, idx_last, done = 0; buffer, counters cleared. Reset mid-row discards all in-flight data.
// FSM: IDLE -> AUX_RD -> AUX_CAP -> STREAM -> DONE -> IDLE.
//  IDLE: on req_valid&&req_ready (cycle T) latch req_row->aux_addr, req_mat->mat_sel; go AUX_RD.
//  AUX_RD (T+1): address stable on aux ROM; go AUX_CAP.
//  AUX_CAP (T+2): capture base=aux_dat[AUX_W-1:HW_W], hw=aux_dat[HW_W-1:0]; mem_addr<=base; hw==0 -> DONE, else STREAM.
//  STREAM: mem_en=1 when issued<hw and (occupancy+inflight)<2; each issue mem_addr+1 mod 2^ADDR_W (wraps 0x7FFF->0x0000).
//   Returned mem_dout pushed into 2-entry output buffer; idx_last set on entry whose sequence no. == hw-1.
//   Leave to DONE in cycle after handshake (idx_valid&&idx_ready) of the last entry.
//  DONE: done=1 for exactly one cycle; next cycle IDLE, req_ready=1.
// Latency: with idx_ready held high, first idx_valid at T+4, one index per cycle thereafter; done at T+4+hw; hw=0 -> done at T+3.
// Handshake: idx_data/idx_last stable while idx_valid&&!idx_ready; no index dropped or duplicated under any ready pattern.
// Backpressure: no mem_en while buffer+inflight==2; mem_addr holds.
// Counters: issued/accepted counts HW_W bits; hw=255 supported without overflow (compare, not increment past hw).
// abort: any non-IDLE state -> IDLE next cycle; buffer flushed, idx_valid=0, no done pulse. abort in IDLE ignored.
// abort and final handshake same cycle: abort wins, no done.
// req_valid outside IDLE ignored (req_ready=0); request not held internally.
// STRUCTURE
// Package row_fetch_pkg: state enum, AUX_W layout field offsets, default widths.
// Sub-module idx_skid_buf: 2-entry FIFO {IDX_W data, last}, push/pop, count[1:0], synchronous flush.
// TESTING
// row=5, mat=B, aux={0x0100,hw=3}, ready=1 -> mem_addr 0x100,0x101,0x102; 3 valids at T+4..T+6, last on 3rd; done at T+7.
// aux hw=0 -> no mem_en, no idx_valid; done at T+3; req_ready back at T+4.
// hw=4, idx_ready low for 5 cycles after 1st handshake -> stream identical to unstalled order, mem_en stops with 2 buffered.
// base=0x7FFF, hw=2 -> mem_addr 0x7FFF then 0x0000.
// abort during STREAM after 2 of hw=6 -> idx_valid 0 next cycle, no done; next request at IDLE served cleanly.
// rst_b low mid-STREAM -> all outputs to reset values next cycle; back-to-back requests (B then A) -> mat_sel toggles, both rows complete.

Source files
------------

// File: rtl/row_fetch_pkg.sv
// Shared types and defaults for the sparse-row index fetch controller.
package row_fetch_pkg;

  localparam int ROW_W_DEF  = 7;
  localparam int ADDR_W_DEF = 15;
  localparam int IDX_W_DEF  = 14;
  localparam int HW_W_DEF   = 8;
  localparam int AUX_W_DEF  = ADDR_W_DEF + HW_W_DEF;

  // Aux word layout: {base[ADDR_W-1:0], hw[HW_W-1:0]}; hw sits at the bottom.
  localparam int AUX_HW_LSB = 0;

  // Output buffer depth; buffered entries plus reads in flight never exceed it.
  localparam logic [1:0] BUF_DEPTH = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AUX_RD  = 3'd1,
    ST_AUX_CAP = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DONE    = 3'd4
  } rf_state_t;

  // True when one more index ROM read can be issued without overrunning the buffer.
  function automatic logic room_to_issue(input logic [1:0] occupancy, input logic inflight);
    return (occupancy + {1'b0, inflight}) < BUF_DEPTH;
  endfunction

endpackage

// File: rtl/idx_skid_buf.sv
// Two-entry FIFO holding {last, index} pairs returned by the index ROM.
module idx_skid_buf #(
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        count
);

  logic [DATA_W:0] slot [2];
  logic            wr_ptr;
  logic            rd_ptr;

  // Pointers and occupancy; reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (!rst_b || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  // Entry storage; contents are meaningless while count says empty.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= {push_last, push_data};
  end

  assign {head_last, head_data} = slot[rd_ptr];

endmodule

// File: rtl/row_fetch_ctrl.sv
// Sparse-row index fetch controller: reads a row's aux word, then streams
// its hw indices from the index ROM onto a valid/ready stream with last flag.
module row_fetch_ctrl
  import row_fetch_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int HW_W   = HW_W_DEF,
  parameter int AUX_W  = ADDR_W + HW_W
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ROW_W-1:0]  req_row,
  input  logic              req_mat,
  input  logic              abort,
  output logic              mat_sel,
  output logic [ROW_W-1:0]  aux_addr,
  input  logic [AUX_W-1:0]  aux_dat,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [IDX_W-1:0]  mem_dout,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [IDX_W-1:0]  idx_data,
  output logic              idx_last,
  output logic              done
);

  rf_state_t         state;
  rf_state_t         state_nxt;

  logic [HW_W-1:0]   hw_q;
  logic [HW_W-1:0]   issued_q;
  logic [HW_W-1:0]   ret_q;
  logic              vld_p1;

  logic [ADDR_W-1:0] aux_base;
  logic [HW_W-1:0]   aux_hw;
  logic              issue;
  logic              rsp_last;
  logic              hs;
  logic              buf_push;
  logic              buf_pop;
  logic              buf_flush;
  logic [1:0]        buf_cnt;
  logic [IDX_W-1:0]  buf_data;
  logic              buf_last;
  logic              buf_empty;

  assign aux_hw   = aux_dat[AUX_HW_LSB +: HW_W];
  assign aux_base = aux_dat[HW_W +: ADDR_W];

  // ---- stage p0: read issue (address register drives the index ROM) ----
  assign issue = (state == ST_STREAM) && !abort && (issued_q < hw_q)
                 && room_to_issue(buf_cnt, vld_p1);
  assign mem_en = issue;

  // ---- stage p1: ROM data returns, either straight to the consumer or into the buffer ----
  assign rsp_last  = (ret_q == hw_q - HW_W'(1));
  assign buf_empty = (buf_cnt == 2'd0);
  assign idx_valid = !buf_empty || vld_p1;
  assign idx_data  = buf_empty ? mem_dout : buf_data;
  assign idx_last  = buf_empty ? rsp_last : buf_last;
  assign hs        = idx_valid && idx_ready;
  assign buf_pop   = hs && !buf_empty;
  assign buf_push  = vld_p1 && !(buf_empty && idx_ready);
  assign buf_flush = abort && (state != ST_IDLE);

  assign req_ready = (state == ST_IDLE);
  assign done      = (state == ST_DONE);

  idx_skid_buf #(
    .DATA_W (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst_b     (rst_b),
    .flush     (buf_flush),
    .push      (buf_push),
    .push_data (mem_dout),
    .push_last (rsp_last),
    .pop       (buf_pop),
    .head_data (buf_data),
    .head_last (buf_last),
    .count     (buf_cnt)
  );

  // Next-state selection; abort from any busy state returns straight to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (req_valid) state_nxt = ST_AUX_RD;
      ST_AUX_RD:  state_nxt = ST_AUX_CAP;
      ST_AUX_CAP: state_nxt = (aux_hw == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM:  if (hs && idx_last) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Request capture: row number to the aux ROM, matrix select to the ROM muxes.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      aux_addr <= '0;
      mat_sel  <= 1'b0;
    end else if ((state == ST_IDLE) && req_valid) begin
      aux_addr <= req_row;
      mat_sel  <= req_mat;
    end
  end

  // Aux word capture and index ROM address walk (wraps modulo 2^ADDR_W).
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      mem_addr <= '0;
      hw_q     <= '0;
    end else if (state == ST_AUX_CAP) begin
      mem_addr <= aux_base;
      hw_q     <= aux_hw;
    end else if (issue) begin
      mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

  // Issue/return counters; bounded by hw through the compare, so hw=max never overflows.
  always_ff @(posedge clk) begin
    if (!rst_b || (state == ST_AUX_CAP)) begin
      issued_q <= '0;
      ret_q    <= '0;
    end else begin
      if (issue)  issued_q <= issued_q + HW_W'(1);
      if (vld_p1) ret_q    <= ret_q + HW_W'(1);
    end
  end

  // Read-in-flight flag marking mem_dout as valid this cycle.
  always_ff @(posedge clk) begin
    if (!rst_b) vld_p1 <= 1'b0;
    else        vld_p1 <= issue;
  end

endmodule

// File: tb/tb_row_fetch_ctrl.sv
// Directed bench for row_fetch_ctrl with behavioural aux and index ROMs.
module tb_row_fetch_ctrl;

  logic        clk;
  logic        rst_b;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_row;
  logic        req_mat;
  logic        abort;
  logic        mat_sel;
  logic [6:0]  aux_addr;
  logic [22:0] aux_dat;
  logic [14:0] mem_addr;
  logic        mem_en;
  logic [13:0] mem_dout;
  logic        idx_valid;
  logic        idx_ready;
  logic [13:0] idx_data;
  logic        idx_last;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [22:0] aux_rom [256];

  row_fetch_ctrl dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_row   (req_row),
    .req_mat   (req_mat),
    .abort     (abort),
    .mat_sel   (mat_sel),
    .aux_addr  (aux_addr),
    .aux_dat   (aux_dat),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_dout  (mem_dout),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx_data  (idx_data),
    .idx_last  (idx_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index ROM content as a function of address and matrix.
  function automatic logic [13:0] idx_f(input logic [14:0] a, input logic mat);
    return a[13:0] ^ (mat ? 14'h2AAA : 14'h1555) ^ {a[14], 13'd0};
  endfunction

  always @(posedge clk) aux_dat <= aux_rom[{mat_sel, aux_addr}];
  always @(posedge clk) if (mem_en) mem_dout <= idx_f(mem_addr, mat_sel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enters cycle T with a request, leaves positioned in cycle T+1.
  task automatic request(input logic [6:0] row, input logic mat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_row = row; req_mat = mat;
    #1;
    chk("req_ready_idle", req_ready, 1);
    chk("done_idle", done, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    chk("aux_addr", aux_addr, row);
    chk("mat_sel", mat_sel, mat);
    chk("req_ready_busy", req_ready, 0);
  endtask

  // Follows one row from T+2; cycle numbers are relative to the request cycle T.
  task automatic stream_row(input logic [14:0] base, input int hw, input logic mat,
                            input int stall_from, input int stall_len, input int abort_after,
                            output int first_v, output int done_at, output int n_hs);
    int          issues;
    int          ab_c;
    logic        prev_stall;
    logic [13:0] pdata;
    logic        plast;
    logic [14:0] ea;
    first_v = -1; done_at = -1; n_hs = 0; issues = 0; ab_c = -1;
    prev_stall = 1'b0; pdata = '0; plast = 1'b0;
    for (int c = 2; c < 400; c++) begin
      @(posedge clk); #1;
      idx_ready = 1'b1; abort = 1'b0;
      if (stall_len > 0 && c >= stall_from && c < stall_from + stall_len) idx_ready = 1'b0;
      if (abort_after >= 0 && ab_c < 0 && n_hs == abort_after) begin
        abort = 1'b1; idx_ready = 1'b0; ab_c = c;
      end
      #1;
      if (ab_c >= 0 && c == ab_c + 1) begin
        chk("abort_valid", idx_valid, 0);
        chk("abort_req_ready", req_ready, 1);
      end
      if (prev_stall) begin
        chk("hold_valid", idx_valid, 1);
        chk("hold_data", idx_data, pdata);
        chk("hold_last", idx_last, plast);
      end
      if (mem_en) begin
        ea = base + 15'(issues);
        chk("mem_addr", mem_addr, ea);
        chk("outstanding", (issues - n_hs) < 2, 1);
        issues++;
      end
      if (idx_valid && first_v < 0) first_v = c;
      prev_stall = idx_valid && !idx_ready && !abort;
      pdata = idx_data; plast = idx_last;
      if (idx_valid && idx_ready) begin
        ea = base + 15'(n_hs);
        chk("idx_data", idx_data, idx_f(ea, mat));
        chk("idx_last", idx_last, n_hs == hw - 1);
        n_hs++;
      end
      if (done) begin done_at = c; break; end
      if (ab_c >= 0 && c == ab_c + 3) break;
    end
    abort = 1'b0; idx_ready = 1'b1;
    if (abort_after < 0) chk("issue_count", issues, hw);
  endtask

  int fv, da, nh;

  initial begin
    for (int i = 0; i < 256; i++) aux_rom[i] = '0;
    aux_rom[{1'b0, 7'd5}]  = {15'h0100, 8'd3};
    aux_rom[{1'b0, 7'd9}]  = {15'h0555, 8'd0};
    aux_rom[{1'b1, 7'd12}] = {15'h0040, 8'd4};
    aux_rom[{1'b1, 7'd20}] = {15'h7FFF, 8'd2};
    aux_rom[{1'b0, 7'd33}] = {15'h0200, 8'd6};
    aux_rom[{1'b1, 7'd40}] = {15'h0300, 8'd6};
    aux_rom[{1'b1, 7'd60}] = {15'h7F80, 8'd255};

    rst_b = 1'b0; req_valid = 1'b0; req_row = '0; req_mat = 1'b0;
    abort = 1'b0; idx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_idx_valid", idx_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mat_sel", mat_sel, 0);
    chk("rst_aux_addr", aux_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_idx_last", idx_last, 0);
    rst_b = 1'b1;
    #1;

    // Basic row: base 0x100, hw 3, matrix B.
    request(7'd5, 1'b0);
    stream_row(15'h0100, 3, 1'b0, 0, 0, -1, fv, da, nh);
    chk("r1_first_valid", fv, 4);
    chk("r1_done_at", da, 7);
    chk("r1_count", nh, 3);

    // Empty row: done at T+3, request accepted again at T+4.
    request(7'd9, 1'b0);
    stream_row(15'h0555, 0, 1'b0, 0, 0, -1, fv, da, nh);
    chk("r2_no_valid", fv, -1);
    chk("r2_done_at", da, 3);

    // Stall for 5 cycles after the first handshake.
    request(7'd12, 1'b1);
    stream_row(15'h0040, 4, 1'b1, 5, 5, -1, fv, da, nh);
    chk("r3_first_valid", fv, 4);
    chk("r3_done_at", da, 13);
    chk("r3_count", nh, 4);

    // Address wrap 0x7FFF -> 0x0000.
    request(7'd20, 1'b1);
    stream_row(15'h7FFF, 2, 1'b1, 0, 0, -1, fv, da, nh);
    chk("r4_done_at", da, 6);
    chk("r4_count", nh, 2);

    // Abort after 2 of 6 indices: no done pulse.
    request(7'd33, 1'b0);
    stream_row(15'h0200, 6, 1'b0, 0, 0, 2, fv, da, nh);
    chk("r5_no_done", da, -1);
    chk("r5_count", nh, 2);

    // Clean row after abort.
    request(7'd5, 1'b0);
    stream_row(15'h0100, 3, 1'b0, 0, 0, -1, fv, da, nh);
    chk("r6_done_at", da, 7);
    chk("r6_count", nh, 3);

    // Reset in the middle of a stream.
    request(7'd40, 1'b1);
    repeat (4) begin @(posedge clk); #2; end
    @(posedge clk); #1; rst_b = 1'b0; #1;
    @(posedge clk); #1; rst_b = 1'b1; #1;
    chk("mid_rst_idx_valid", idx_valid, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_mat_sel", mat_sel, 0);
    chk("mid_rst_aux_addr", aux_addr, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_idx_last", idx_last, 0);

    // Back-to-back rows: matrix B then matrix A.
    request(7'd5, 1'b0);
    stream_row(15'h0100, 3, 1'b0, 0, 0, -1, fv, da, nh);
    chk("b2b_b_done_at", da, 7);
    request(7'd20, 1'b1);
    stream_row(15'h7FFF, 2, 1'b1, 0, 0, -1, fv, da, nh);
    chk("b2b_a_done_at", da, 6);

    // Maximum Hamming weight.
    request(7'd60, 1'b1);
    stream_row(15'h7F80, 255, 1'b1, 0, 0, -1, fv, da, nh);
    chk("hw255_done_at", da, 259);
    chk("hw255_count", nh, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
